dekatron_counter_driver: RTL and testbench

Command-side initiator for the DekatronCounter Request/Ready interface. Accepts one high-level command (step N times up/down, load a value, or seek to a target value), then issues single-cycle `Request` pulses with stable `Dec`/`Set`/`In` and waits for the counter's `Ready` after each. Sits between the sequencer/control logic and an IP or AP DekatronCounter, replacing ad-hoc request toggling in callers.

---
 rtl/dekatron_pkg.sv | 29 ++
 rtl/handshake_watchdog.sv | 52 +++++
 rtl/dekatron_counter_driver.sv | 170 +++++++++++++++++
 tb/tb_dekatron_counter_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dekatron_pkg.sv
// -----------------------------------------------------------------------------
// dekatron_pkg
// Definitions shared by the DekatronCounter command driver and its helper
// blocks:
//   BCD_W        - bits per BCD digit (one dekatron)
//   drv_op_t     - command opcodes accepted by the driver
//   drv_state_t  - driver FSM states
// Optional feature macro used by the driver: DEKATRON_DRIVER_TIMEOUT_EN
// -----------------------------------------------------------------------------
package dekatron_pkg;

   localparam int BCD_W = 4;

   typedef enum logic [1:0] {
      OP_STEP = 2'd0,
      OP_LOAD = 2'd1,
      OP_SEEK = 2'd2
   } drv_op_t;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_ISSUE     = 3'd1,
      S_WAIT_BUSY = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_CHECK     = 3'd4,
      S_FINISH    = 3'd5
   } drv_state_t;

endpackage

// File: rtl/handshake_watchdog.sv
// -----------------------------------------------------------------------------
// handshake_watchdog
// Counts the cycles the driver FSM spends in one handshake state (ISSUE,
// WAIT_BUSY or WAIT_DONE). The count restarts whenever the state changes and
// Expired is raised in the TIMEOUT-th consecutive cycle of the same state.
// The whole module only exists when DEKATRON_DRIVER_TIMEOUT_EN is defined.
//
// Ports:
//   Clk      in  system clock (rising edge)
//   Rst      in  asynchronous active-high reset
//   State    in  current driver FSM state
//   Expired  out handshake phase has run out of time (combinational)
// -----------------------------------------------------------------------------
`ifdef DEKATRON_DRIVER_TIMEOUT_EN
module handshake_watchdog
   import dekatron_pkg::*;
#(
   parameter int TIMEOUT = 1024
) (
   input  logic       Clk,
   input  logic       Rst,
   input  drv_state_t State,
   output logic       Expired
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   drv_state_t       last_state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] elapsed;
   logic             active;

   // elapsed is the number of cycles already spent in the current state,
   // so a freshly entered state always starts at zero.
   always_comb begin
      active  = (State == S_ISSUE) || (State == S_WAIT_BUSY) || (State == S_WAIT_DONE);
      elapsed = (State == last_state) ? cnt : '0;
      Expired = active && (elapsed == CNT_W'(TIMEOUT - 1));
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         last_state <= S_IDLE;
         cnt        <= '0;
      end else begin
         last_state <= State;
         cnt        <= active ? (elapsed + CNT_W'(1)) : '0;
      end
   end

endmodule
`endif

// File: rtl/dekatron_counter_driver.sv
// -----------------------------------------------------------------------------
// dekatron_counter_driver
// Command-side initiator for a DekatronCounter Request/Ready interface.
// Takes one command (STEP n times, LOAD a value, SEEK a target), then issues
// single-cycle Request pulses with stable Dec/Set/In, waiting for the counter
// to go busy and return to Ready after each one.
//
// Optional feature: define DEKATRON_DRIVER_TIMEOUT_EN to add a per-phase
// watchdog (handshake_watchdog); TIMEOUT is only meaningful with it.
//
// Ports:
//   Clk, Rst         clock, asynchronous active-high reset
//   CmdValid/Ready   command handshake (accept on CmdValid & CmdReady)
//   CmdOp            0 STEP, 1 LOAD, 2 SEEK, 3 reserved (= STEP of 0)
//   CmdDec           direction for STEP/SEEK (1 = decrement)
//   CmdCount         number of steps for STEP
//   CmdValue         BCD load value (LOAD) or target (SEEK)
//   Done             one-cycle pulse at command completion
//   Err              sticky error, cleared by the next accepted command
//   StepsDone        Requests completed for the current/last command
//   Request          one-cycle pulse to the counter
//   Dec, Set, In     counter controls / load data
//   Ready, Out       counter idle flag and BCD value
// -----------------------------------------------------------------------------
module dekatron_counter_driver
   import dekatron_pkg::*;
#(
   parameter int D_NUM   = 6,
   parameter int STEP_W  = 16,
   parameter int TIMEOUT = 1024
) (
   input  logic                   Clk,
   input  logic                   Rst,
   input  logic                   CmdValid,
   input  logic [1:0]             CmdOp,
   input  logic                   CmdDec,
   input  logic [STEP_W-1:0]      CmdCount,
   input  logic [D_NUM*BCD_W-1:0] CmdValue,
   output logic                   CmdReady,
   output logic                   Done,
   output logic                   Err,
   output logic [STEP_W-1:0]      StepsDone,
   output logic                   Request,
   output logic                   Dec,
   output logic                   Set,
   output logic [D_NUM*BCD_W-1:0] In,
   input  logic                   Ready,
   input  logic [D_NUM*BCD_W-1:0] Out
);

   localparam int VAL_W = D_NUM * BCD_W;

   if (TIMEOUT < 2) begin : g_timeout_range
      $error("TIMEOUT must be at least 2");
   end

   drv_state_t        state;
   drv_op_t           op_q;
   logic [STEP_W-1:0] count_q;
   logic [VAL_W-1:0]  value_q;
   logic              op_done;
   logic              wd_expired;

`ifdef DEKATRON_DRIVER_TIMEOUT_EN
   handshake_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .Clk     (Clk),
      .Rst     (Rst),
      .State   (state),
      .Expired (wd_expired)
   );
`else
   assign wd_expired = 1'b0;
`endif

   // Completion test evaluated in CHECK; Out here already reflects the
   // step that finished when Ready was seen high one cycle earlier.
   always_comb begin
      op_done = 1'b1;
      case (op_q)
         OP_STEP: op_done = (StepsDone == count_q);
         OP_LOAD: op_done = (StepsDone != '0);
         OP_SEEK: op_done = (Out == value_q);
         default: op_done = 1'b1;
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= S_IDLE;
         CmdReady  <= 1'b0;
         Done      <= 1'b0;
         Err       <= 1'b0;
         StepsDone <= '0;
         Request   <= 1'b0;
         Dec       <= 1'b0;
         Set       <= 1'b0;
         In        <= '0;
         op_q      <= OP_STEP;
         count_q   <= '0;
         value_q   <= '0;
      end else begin
         Request <= 1'b0;
         Done    <= 1'b0;
         if (wd_expired) begin
            // Abandon the handshake; Request stays low via the default above.
            Err   <= 1'b1;
            Done  <= 1'b1;
            state <= S_FINISH;
         end else begin
            case (state)
               S_IDLE: begin
                  CmdReady <= 1'b1;
                  if (CmdValid && CmdReady) begin
                     CmdReady  <= 1'b0;
                     StepsDone <= '0;
                     Err       <= 1'b0;
                     Dec       <= CmdDec;
                     value_q   <= CmdValue;
                     if (CmdOp == 2'd3) begin
                        op_q    <= OP_STEP;
                        count_q <= '0;
                     end else begin
                        op_q    <= drv_op_t'(CmdOp);
                        count_q <= CmdCount;
                     end
                     Set <= (CmdOp == 2'd1);
                     In  <= (CmdOp == 2'd1) ? CmdValue : '0;
                     state <= S_CHECK;
                  end
               end
               S_CHECK: begin
                  if (op_done) begin
                     Done  <= 1'b1;
                     state <= S_FINISH;
                  end else if (&StepsDone) begin
                     Err   <= 1'b1;
                     Done  <= 1'b1;
                     state <= S_FINISH;
                  end else begin
                     state <= S_ISSUE;
                  end
               end
               S_ISSUE: begin
                  if (Ready) begin
                     Request <= 1'b1;
                     state   <= S_WAIT_BUSY;
                  end
               end
               S_WAIT_BUSY: begin
                  if (!Ready) state <= S_WAIT_DONE;
               end
               S_WAIT_DONE: begin
                  if (Ready) begin
                     if (!(&StepsDone)) StepsDone <= StepsDone + STEP_W'(1);
                     state <= S_CHECK;
                  end
               end
               S_FINISH: begin
                  CmdReady <= 1'b1;
                  state    <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dekatron_counter_driver.sv
module tb_dekatron_counter_driver;

   localparam int D_NUM   = 6;
   localparam int STEP_W  = 16;
   localparam int TIMEOUT = 16;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        CmdValid = 1'b0;
   logic [1:0]  CmdOp = 2'd0;
   logic        CmdDec = 1'b0;
   logic [15:0] CmdCount = '0;
   logic [23:0] CmdValue = '0;
   logic        CmdReady, Done, Err, Request, Dec, Set;
   logic [15:0] StepsDone;
   logic [23:0] In;
   logic        Ready;
   logic [23:0] Out = '0;

   // behavioural counter
   logic        ready_m = 1'b1;
   logic        hold_low = 1'b0;
   int          extra = 0;
   int          busy_cnt = 0;
   logic        pend_dec = 1'b0;
   logic        pend_set = 1'b0;
   logic [23:0] pend_in = '0;
   int          req_cnt = 0;
   int          req_double = 0;
   logic        req_prev = 1'b0;

   int n_cmp = 0;
   int n_err = 0;

   always #5 Clk = ~Clk;

   assign Ready = ready_m & ~hold_low;

   dekatron_counter_driver #(
      .D_NUM   (D_NUM),
      .STEP_W  (STEP_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .Clk       (Clk),
      .Rst       (Rst),
      .CmdValid  (CmdValid),
      .CmdOp     (CmdOp),
      .CmdDec    (CmdDec),
      .CmdCount  (CmdCount),
      .CmdValue  (CmdValue),
      .CmdReady  (CmdReady),
      .Done      (Done),
      .Err       (Err),
      .StepsDone (StepsDone),
      .Request   (Request),
      .Dec       (Dec),
      .Set       (Set),
      .In        (In),
      .Ready     (Ready),
      .Out       (Out)
   );

   function automatic logic [23:0] bcd_step(input logic [23:0] v, input logic dn);
      logic [23:0] r;
      logic [3:0]  d;
      logic        carry;
      r = v;
      carry = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (carry) begin
            d = r[i*4 +: 4];
            if (!dn) begin
               if (d == 4'd9) d = 4'd0;
               else begin d = d + 4'd1; carry = 1'b0; end
            end else begin
               if (d == 4'd0) d = 4'd9;
               else begin d = d - 4'd1; carry = 1'b0; end
            end
            r[i*4 +: 4] = d;
         end
      end
      return r;
   endfunction

   // Counter: goes busy the edge after it sees Request, updates Out and
   // returns Ready after 1+extra further edges.
   always @(posedge Clk) begin
      req_prev <= Request;
      if (Request) begin
         req_cnt <= req_cnt + 1;
         if (req_prev) req_double <= req_double + 1;
      end
      if (Request && Ready) begin
         ready_m  <= 1'b0;
         busy_cnt <= 1 + extra;
         pend_dec <= Dec;
         pend_set <= Set;
         pend_in  <= In;
      end else if (busy_cnt == 1) begin
         Out      <= pend_set ? pend_in : bcd_step(Out, pend_dec);
         ready_m  <= 1'b1;
         busy_cnt <= 0;
      end else if (busy_cnt > 1) begin
         busy_cnt <= busy_cnt - 1;
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic dn, input logic [15:0] cnt,
                          input logic [23:0] val, input string tag,
                          output int lat, output int nreq);
      int r0;
      int w;
      @(negedge Clk);
      CmdValid = 1'b1; CmdOp = op; CmdDec = dn; CmdCount = cnt; CmdValue = val;
      w = 0;
      while (!CmdReady && w < 100) begin @(negedge Clk); w++; end
      check_val({tag, "_accept"}, 64'(CmdReady), 64'd1);
      r0 = req_cnt;
      @(negedge Clk);
      CmdValid = 1'b0;
      lat = 1;
      while (!Done && lat < 3000) begin @(negedge Clk); lat++; end
      check_val({tag, "_done"}, 64'(Done), 64'd1);
      nreq = req_cnt - r0;
   endtask

   initial begin
      int lat;
      int nreq;
      int w;

      // reset values
      #1 Rst = 1'b1;
      #1;
      check_val("rst_cmdready", 64'(CmdReady), 64'd0);
      check_val("rst_request", 64'(Request), 64'd0);
      check_val("rst_done", 64'(Done), 64'd0);
      check_val("rst_err", 64'(Err), 64'd0);
      check_val("rst_dec_set", {62'd0, Dec, Set}, 64'd0);
      check_val("rst_in", 64'(In), 64'd0);
      check_val("rst_steps", 64'(StepsDone), 64'd0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      @(negedge Clk);
      check_val("rst_release_cmdready", 64'(CmdReady), 64'd1);

      // STEP up 5 from 000000
      run_cmd(2'd0, 1'b0, 16'd5, 24'h0, "step5", lat, nreq);
      check_val("step5_lat", 64'(lat), 64'd27);
      check_val("step5_nreq", 64'(nreq), 64'd5);
      check_val("step5_out", 64'(Out), 64'h000005);
      check_val("step5_steps", 64'(StepsDone), 64'd5);
      check_val("step5_err", 64'(Err), 64'd0);
      @(negedge Clk);
      check_val("step5_done_pulse", 64'(Done), 64'd0);
      check_val("step5_cmdready", 64'(CmdReady), 64'd1);

      // LOAD 123456
      run_cmd(2'd1, 1'b0, 16'd0, 24'h123456, "load", lat, nreq);
      check_val("load_lat", 64'(lat), 64'd7);
      check_val("load_nreq", 64'(nreq), 64'd1);
      check_val("load_set", 64'(Set), 64'd1);
      check_val("load_in", 64'(In), 64'h123456);
      check_val("load_out", 64'(Out), 64'h123456);
      check_val("load_steps", 64'(StepsDone), 64'd1);

      // STEP down 3 from 000001 wraps to 999998
      run_cmd(2'd1, 1'b0, 16'd0, 24'h000001, "load1", lat, nreq);
      check_val("load1_out", 64'(Out), 64'h000001);
      run_cmd(2'd0, 1'b1, 16'd3, 24'h0, "stepdn", lat, nreq);
      check_val("stepdn_out", 64'(Out), 64'h999998);
      check_val("stepdn_nreq", 64'(nreq), 64'd3);
      check_val("stepdn_err", 64'(Err), 64'd0);
      check_val("stepdn_ctl", {62'd0, Dec, Set}, 64'd2);
      check_val("stepdn_in", 64'(In), 64'd0);

      // SEEK up from 000002 to 000007, then SEEK to current value
      run_cmd(2'd1, 1'b0, 16'd0, 24'h000002, "load2", lat, nreq);
      run_cmd(2'd2, 1'b0, 16'd0, 24'h000007, "seek", lat, nreq);
      check_val("seek_nreq", 64'(nreq), 64'd5);
      check_val("seek_out", 64'(Out), 64'h000007);
      check_val("seek_steps", 64'(StepsDone), 64'd5);
      run_cmd(2'd2, 1'b0, 16'd0, 24'h000007, "seekhere", lat, nreq);
      check_val("seekhere_nreq", 64'(nreq), 64'd0);
      check_val("seekhere_lat", 64'(lat), 64'd2);
      check_val("seekhere_steps", 64'(StepsDone), 64'd0);

      // STEP of 0 and reserved opcode
      run_cmd(2'd0, 1'b0, 16'd0, 24'h0, "step0", lat, nreq);
      check_val("step0_lat", 64'(lat), 64'd2);
      check_val("step0_nreq", 64'(nreq), 64'd0);
      run_cmd(2'd3, 1'b0, 16'd9, 24'h0, "rsvd", lat, nreq);
      check_val("rsvd_nreq", 64'(nreq), 64'd0);
      check_val("rsvd_out", 64'(Out), 64'h000007);

      // reset while waiting for the counter to finish a step
      extra = 4;
      @(negedge Clk);
      CmdValid = 1'b1; CmdOp = 2'd0; CmdDec = 1'b0; CmdCount = 16'd1;
      w = 0;
      while (!CmdReady && w < 100) begin @(negedge Clk); w++; end
      @(negedge Clk);
      CmdValid = 1'b0;
      w = 0;
      while (Ready && w < 100) begin @(negedge Clk); w++; end
      check_val("midrst_busy_seen", 64'(Ready), 64'd0);
      @(negedge Clk);
      #1 Rst = 1'b1;
      #1;
      check_val("midrst_request", 64'(Request), 64'd0);
      check_val("midrst_cmdready", 64'(CmdReady), 64'd0);
      check_val("midrst_steps", 64'(StepsDone), 64'd0);
      @(negedge Clk);
      Rst = 1'b0;
      extra = 0;
      @(negedge Clk);
      check_val("midrst_release_cmdready", 64'(CmdReady), 64'd1);
      repeat (6) @(negedge Clk);
      check_val("midrst_counter_kept", 64'(Out), 64'h000008);
      run_cmd(2'd0, 1'b0, 16'd1, 24'h0, "after_rst", lat, nreq);
      check_val("after_rst_out", 64'(Out), 64'h000009);
      check_val("after_rst_steps", 64'(StepsDone), 64'd1);
      check_val("after_rst_nreq", 64'(nreq), 64'd1);

`ifdef DEKATRON_DRIVER_TIMEOUT_EN
      // counter never ready: watchdog ends the command in ISSUE
      hold_low = 1'b1;
      run_cmd(2'd0, 1'b0, 16'd1, 24'h0, "tmo", lat, nreq);
      check_val("tmo_lat", 64'(lat), 64'd18);
      check_val("tmo_err", 64'(Err), 64'd1);
      check_val("tmo_nreq", 64'(nreq), 64'd0);
      hold_low = 1'b0;
      run_cmd(2'd0, 1'b0, 16'd0, 24'h0, "tmo_clear", lat, nreq);
      check_val("tmo_clear_err", 64'(Err), 64'd0);
`endif

      check_val("request_never_back_to_back", 64'(req_double), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
